// File: rtl/microwave_timer_ctrl_pkg.sv
// Shared types for the microwave timer controller: FSM state encoding and
// the width of the power-level input.
package microwave_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPEN  = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    BELL  = 3'd4
  } state_t;

  // Power must encode 0..PWR_STEPS inclusive (PWR_STEPS = continuous heat).
  function automatic int pwr_width(input int steps);
    return $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/microwave_timer_ctrl_tick_prescaler.sv
// Seconds prescaler: counts 0..TICKS-1 while enabled and pulses tick on the
// last count. The count is held when disabled so a partial second survives.
module tick_prescaler #(
  parameter int TICKS = 1000
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int TW = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [TW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == TW'(TICKS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave controller: door/keypad FSM, seconds cook timer, power duty-cycle
// frame and timed bell. Outputs are decoded from registered state only.
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int TICKS_PER_SEC = 1000,
  parameter int PWR_STEPS     = 4,
  parameter int BELL_SECS     = 3
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic                              door,
  input  logic                              start,
  input  logic                              cancel,
  input  logic                              load,
  input  logic [CNT_W-1:0]                  load_secs,
  input  logic [pwr_width(PWR_STEPS)-1:0]   power,
  output logic                              heat,
  output logic                              light,
  output logic                              bell,
  output logic [CNT_W-1:0]                  remaining,
  output logic                              busy
);

  localparam int PW = pwr_width(PWR_STEPS);
  localparam int FW = $clog2(PWR_STEPS);
  localparam int BW = (BELL_SECS > 1) ? $clog2(BELL_SECS) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [PW-1:0]    pwr_q, pwr_d;
  logic [FW-1:0]    frame_q, frame_d;
  logic [BW-1:0]    bell_cnt_q, bell_cnt_d;
  logic             sec_tick;
  logic             pre_en;
  logic             pre_clr;

  assign pre_en = (state_q == COOK) || (state_q == BELL);

  tick_prescaler #(
    .TICKS (TICKS_PER_SEC)
  ) u_sec_prescaler (
    .clk  (clk),
    .nrst (nrst),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (sec_tick)
  );

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    pwr_d      = pwr_q;
    bell_cnt_d = bell_cnt_q;
    pre_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) rem_d = load_secs;
        // start is qualified by the timer value before any same-cycle load
        if (door) begin
          state_d = OPEN;
        end else if (start && (rem_q != '0)) begin
          state_d = COOK;
          pwr_d   = power;
          pre_clr = 1'b1;
        end
      end
      OPEN: begin
        if (load) rem_d = load_secs;
        if (!door) state_d = IDLE;
      end
      COOK: begin
        if (door) begin
          state_d = PAUSE;
        end else if (cancel) begin
          state_d = IDLE;
          rem_d   = '0;
        end else if (sec_tick && (rem_q != '0)) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d    = BELL;
            pre_clr    = 1'b1;
            bell_cnt_d = '0;
          end
        end
      end
      PAUSE: begin
        if (cancel) begin
          state_d = OPEN;
          rem_d   = '0;
        end else if (!door) begin
          state_d = COOK;
        end
      end
      BELL: begin
        if (door) begin
          state_d = OPEN;
        end else if (cancel) begin
          state_d = IDLE;
        end else if (sec_tick) begin
          if (bell_cnt_q == BW'(BELL_SECS - 1)) state_d = IDLE;
          else bell_cnt_d = bell_cnt_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Duty frame runs only while cooking and restarts with the prescaler.
  always_comb begin
    frame_d = frame_q;
    if (pre_clr) begin
      frame_d = '0;
    end else if (state_q == COOK) begin
      frame_d = (frame_q == FW'(PWR_STEPS - 1)) ? '0 : frame_q + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      pwr_q      <= '0;
      frame_q    <= '0;
      bell_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      pwr_q      <= pwr_d;
      frame_q    <= frame_d;
      bell_cnt_q <= bell_cnt_d;
    end
  end

  always_comb begin
    heat  = 1'b0;
    light = 1'b0;
    bell  = 1'b0;
    busy  = 1'b0;
    case (state_q)
      OPEN:  light = 1'b1;
      COOK: begin
        light = 1'b1;
        busy  = 1'b1;
        heat  = PW'(frame_q) < pwr_q;
      end
      PAUSE: begin
        light = 1'b1;
        busy  = 1'b1;
      end
      BELL:  bell = 1'b1;
      default: ;
    endcase
  end

  assign remaining = rem_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Scoreboard bench for microwave_timer_ctrl: a cycle-level behavioural model
// predicts outputs per clock; a monitor compares them after each rising edge.
module tb_microwave_timer_ctrl;

  localparam int CNT_W = 4;
  localparam int TPS   = 4;
  localparam int PS    = 4;
  localparam int BSECS = 2;

  logic       clk = 1'b0;
  logic       nrst, door, start, cancel, load;
  logic [3:0] load_secs;
  logic [2:0] power;
  logic       heat, light, bell, busy;
  logic [3:0] remaining;

  microwave_timer_ctrl #(
    .CNT_W         (CNT_W),
    .TICKS_PER_SEC (TPS),
    .PWR_STEPS     (PS),
    .BELL_SECS     (BSECS)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .door      (door),
    .start     (start),
    .cancel    (cancel),
    .load      (load),
    .load_secs (load_secs),
    .power     (power),
    .heat      (heat),
    .light     (light),
    .bell      (bell),
    .remaining (remaining),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       heat;
    logic       light;
    logic       bell;
    logic       busy;
    logic [3:0] rem;
  } obs_t;

  obs_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural model: time is tracked as cycles spent cooking / ringing.
  typedef enum {M_IDLE, M_OPEN, M_COOK, M_PAUSE, M_BELL} mmode_t;
  mmode_t m_st;
  int     m_rem, m_pwr, m_cook_age, m_bell_age;

  task automatic model_reset();
    m_st = M_IDLE;
    m_rem = 0;
    m_pwr = 0;
    m_cook_age = 0;
    m_bell_age = 0;
  endtask

  task automatic model_step(input bit d, s, c, l, input int ls, input int pw);
    int  old_rem;
    bit  sec_done;
    old_rem = m_rem;
    case (m_st)
      M_IDLE: begin
        if (l) m_rem = ls;
        if (d) m_st = M_OPEN;
        else if (s && old_rem != 0) begin
          m_st = M_COOK;
          m_pwr = pw;
          m_cook_age = 0;
        end
      end
      M_OPEN: begin
        if (l) m_rem = ls;
        if (!d) m_st = M_IDLE;
      end
      M_COOK: begin
        sec_done = ((m_cook_age + 1) % TPS) == 0;
        m_cook_age++;
        if (d) m_st = M_PAUSE;
        else if (c) begin
          m_st = M_IDLE;
          m_rem = 0;
        end else if (sec_done && m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) begin
            m_st = M_BELL;
            m_bell_age = 0;
          end
        end
      end
      M_PAUSE: begin
        if (c) begin
          m_st = M_OPEN;
          m_rem = 0;
        end else if (!d) m_st = M_COOK;
      end
      M_BELL: begin
        m_bell_age++;
        if (d) m_st = M_OPEN;
        else if (c) m_st = M_IDLE;
        else if (m_bell_age == BSECS * TPS) m_st = M_IDLE;
      end
      default: m_st = M_IDLE;
    endcase
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.heat  = (m_st == M_COOK) && ((m_cook_age % PS) < m_pwr);
    o.light = (m_st == M_OPEN) || (m_st == M_COOK) || (m_st == M_PAUSE);
    o.bell  = (m_st == M_BELL);
    o.busy  = (m_st == M_COOK) || (m_st == M_PAUSE);
    o.rem   = 4'(m_rem);
    return o;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit d, s, c, l, input int ls, input int pw);
    @(negedge clk);
    nrst      = 1'b1;
    door      = d;
    start     = s;
    cancel    = c;
    load      = l;
    load_secs = 4'(ls);
    power     = 3'(pw);
    model_step(d, s, c, l, ls, pw);
    sb_q.push_back(model_obs());
  endtask

  task automatic idle_cyc();
    drive(door, 1'b0, 1'b0, 1'b0, 0, int'(power));
  endtask

  task automatic do_reset(input bit check_now);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    if (check_now) begin
      chk("async_rst_heat", {7'd0, heat}, 8'd0);
      chk("async_rst_light", {7'd0, light}, 8'd0);
      chk("async_rst_bell", {7'd0, bell}, 8'd0);
      chk("async_rst_busy", {7'd0, busy}, 8'd0);
      chk("async_rst_rem", {4'd0, remaining}, 8'd0);
    end
    model_reset();
    sb_q.push_back(model_obs());
  endtask

  task automatic at_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every rising edge the DUT presents a new output word.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      a.heat = heat; a.light = light; a.bell = bell; a.busy = busy; a.rem = remaining;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: no expected entry at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL sb_outputs: got h%0b l%0b b%0b y%0b r%0d expected h%0b l%0b b%0b y%0b r%0d at %0t",
                   a.heat, a.light, a.bell, a.busy, a.rem,
                   e.heat, e.light, e.bell, e.busy, e.rem, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit rd;
    nrst = 1'b0; door = 1'b0; start = 1'b0; cancel = 1'b0; load = 1'b0;
    load_secs = '0; power = '0;
    model_reset();
    sb_q.push_back(model_obs());

    // Full cook at continuous power, then bell
    drive(0, 0, 0, 1, 3, 0);
    drive(0, 1, 0, 0, 0, 4);
    for (int k = 1; k <= 20; k++) begin
      idle_cyc();
      at_edge();
      if (k == 3)  chk("t1_heat_full", {7'd0, heat}, 8'd1);
      if (k == 4)  chk("t1_rem_at4", {4'd0, remaining}, 8'd2);
      if (k == 8)  chk("t1_rem_at8", {4'd0, remaining}, 8'd1);
      if (k == 12) chk("t1_rem_at12", {4'd0, remaining}, 8'd0);
      if (k == 12) chk("t1_bell_on", {7'd0, bell}, 8'd1);
      if (k == 19) chk("t1_bell_last", {7'd0, bell}, 8'd1);
      if (k == 20) chk("t1_bell_off", {7'd0, bell}, 8'd0);
      if (k == 20) chk("t1_idle_light", {7'd0, light}, 8'd0);
    end

    // Quarter power duty pattern, then cancel from COOK
    drive(0, 0, 0, 1, 5, 0);
    drive(0, 1, 0, 0, 0, 1);
    at_edge();
    chk("t2_heat_k0", {7'd0, heat}, 8'd1);
    for (int k = 1; k < 8; k++) begin
      idle_cyc();
      at_edge();
      chk("t2_heat_pat", {7'd0, heat}, (k % 4 == 0) ? 8'd1 : 8'd0);
      chk("t2_light", {7'd0, light}, 8'd1);
    end
    drive(0, 0, 1, 0, 0, 1);
    at_edge();
    chk("t5_cancel_cook_rem", {4'd0, remaining}, 8'd0);
    chk("t5_cancel_cook_busy", {7'd0, busy}, 8'd0);

    // Start ignored with empty timer; load while door open
    drive(0, 1, 0, 0, 0, 4);
    at_edge();
    chk("t4_start_zero_busy", {7'd0, busy}, 8'd0);
    drive(1, 1, 0, 0, 0, 4);
    at_edge();
    chk("t4_open_light", {7'd0, light}, 8'd1);
    drive(1, 0, 0, 1, 7, 4);
    at_edge();
    chk("t4_open_load", {4'd0, remaining}, 8'd7);
    drive(0, 0, 0, 0, 0, 4);
    at_edge();
    chk("t4_close_idle", {7'd0, light}, 8'd0);

    // Cancel while paused goes to OPEN with timer cleared
    drive(0, 1, 0, 0, 0, 2);
    drive(1, 0, 0, 0, 0, 2);
    at_edge();
    chk("t5_pause_busy", {7'd0, busy}, 8'd1);
    chk("t5_pause_heat", {7'd0, heat}, 8'd0);
    drive(1, 0, 1, 0, 0, 2);
    at_edge();
    chk("t5_cancel_pause_rem", {4'd0, remaining}, 8'd0);
    chk("t5_cancel_pause_light", {7'd0, light}, 8'd1);
    chk("t5_cancel_pause_busy", {7'd0, busy}, 8'd0);
    drive(0, 0, 0, 0, 0, 2);

    // Door during bell
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) idle_cyc();
    at_edge();
    chk("t5_bell_reached", {7'd0, bell}, 8'd1);
    drive(1, 0, 0, 0, 0, 0);
    at_edge();
    chk("t5_bell_door_bell", {7'd0, bell}, 8'd0);
    chk("t5_bell_door_light", {7'd0, light}, 8'd1);
    drive(0, 0, 0, 0, 0, 0);

    // Pause keeps the partial second
    drive(0, 0, 0, 1, 5, 0);
    drive(0, 1, 0, 0, 0, 4);
    drive(0, 0, 0, 0, 0, 4);
    drive(1, 0, 0, 0, 0, 4);
    at_edge();
    chk("t3_pause_heat", {7'd0, heat}, 8'd0);
    chk("t3_pause_light", {7'd0, light}, 8'd1);
    for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, 0, 4);
    at_edge();
    chk("t3_pause_frozen", {4'd0, remaining}, 8'd5);
    drive(0, 0, 0, 0, 0, 4);
    at_edge();
    chk("t3_resume_heat", {7'd0, heat}, 8'd1);
    idle_cyc();
    at_edge();
    chk("t3_resume_r1", {4'd0, remaining}, 8'd5);
    idle_cyc();
    at_edge();
    chk("t3_resume_r2", {4'd0, remaining}, 8'd4);

    // Asynchronous reset mid-cook
    drive(0, 0, 1, 0, 0, 4);
    drive(0, 0, 0, 1, 5, 0);
    drive(0, 1, 0, 0, 0, 4);
    idle_cyc();
    at_edge();
    chk("t6_pre_heat", {7'd0, heat}, 8'd1);
    do_reset(1'b1);
    drive(0, 1, 0, 0, 0, 4);
    drive(0, 0, 0, 0, 0, 4);
    at_edge();
    chk("t6_after_busy", {7'd0, busy}, 8'd0);
    chk("t6_after_light", {7'd0, light}, 8'd0);

    // Randomized traffic against the model
    rd = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1'b0);
      end else begin
        if ($urandom_range(0, 11) == 0) rd = !rd;
        drive(rd,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 29) == 0,
              $urandom_range(0, 5) == 0,
              int'($urandom_range(0, 5)),
              int'($urandom_range(0, 7)));
      end
    end

    at_edge();
    chk("sb_drained", 8'(sb_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/microwave_timer_ctrl.md
Name: microwave_timer_ctrl

Overview:
Parametrised microwave controller with a built-in cook timer, power-level duty cycling and a timed bell. It replaces the external `finish` input with an internal seconds countdown loaded by the panel logic. The oven outputs (`heat`, `light`, `bell`) are Moore-style, driven from state plus a power compare. The block sits between the keypad/door sensors and the magnetron/lamp/buzzer drivers.

Parameters:
- CNT_W, 8, width of the seconds counter (max cook time 2^CNT_W-1 s).
- TICKS_PER_SEC, 1000, clk cycles per second; must be >=2.
- PWR_STEPS, 4, length in cycles of one heat duty-cycle frame; must be >=2.
- BELL_SECS, 3, bell duration in seconds; must be >=1.

Ports:
- clk, input, 1, clock.
- nrst, input, 1, reset, asynchronous, active-low.
- door, input, 1, 1 = door open.
- start, input, 1, begin cooking (level sampled each clk).
- cancel, input, 1, abort cook or bell and clear the timer.
- load, input, 1, write `load_secs` into the timer.
- load_secs, input, CNT_W, cook time in seconds.
- power, input, $clog2(PWR_STEPS+1), heat cycles per frame; latched on start.
- heat, output, 1, magnetron enable.
- light, output, 1, cavity lamp.
- bell, output, 1, buzzer.
- remaining, output, CNT_W, seconds left.
- busy, output, 1, high in COOK or PAUSE.

Behaviour:
- Reset (async, nrst=0):
  - state=IDLE; remaining=0; pwr_q=0; prescaler=0; frame counter=0; bell counter=0.
  - Outputs heat=0, light=0, bell=0, busy=0.
- States: IDLE, OPEN, COOK, PAUSE, BELL. Outputs are a function of state:
  - IDLE: all outputs 0.
  - OPEN: light=1.
  - COOK: light=1, busy=1, heat=(frame < pwr_q).
  - PAUSE: light=1, busy=1.
  - BELL: bell=1.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1, advancing only in COOK and BELL.
  - Frozen in PAUSE, so a partial second is kept.
  - Cleared on entry to COOK from IDLE and on entry to BELL.
  - sec_tick=1 for the single cycle where prescaler==TICKS_PER_SEC-1 and it is advancing.
- Frame counter: counts 0..PWR_STEPS-1 continuously in COOK; frozen otherwise; cleared with the prescaler. pwr_q>=PWR_STEPS gives continuous heat; pwr_q=0 gives no heat, but the timer still runs.
- Transitions, evaluated each clk; priority is listed top-down within a state:
  - IDLE:
    - door -> OPEN.
    - else start && remaining!=0 -> COOK, pwr_q<=power.
    - start with remaining==0 is ignored.
  - OPEN: !door -> IDLE.
  - COOK:
    - door -> PAUSE.
    - else cancel -> IDLE, remaining<=0.
    - else if sec_tick: remaining<=remaining-1; if remaining==1 -> BELL.
  - PAUSE:
    - cancel -> OPEN, remaining<=0.
    - else !door -> COOK (auto-resume, no start needed, pwr_q kept).
  - BELL:
    - door -> OPEN.
    - else cancel -> IDLE.
    - else if sec_tick and bell counter==BELL_SECS-1 -> IDLE; else bell counter increments on sec_tick.
    - Bell counter is cleared on entry to BELL.
- load:
  - Honoured only in IDLE and OPEN: remaining<=load_secs next cycle.
  - Ignored in COOK, PAUSE and BELL.
  - load and start together in IDLE: the load takes effect and start is evaluated against the old remaining (registered compare).
- Door opening on the same cycle as the final sec_tick: door wins, state -> PAUSE, remaining unchanged, and the tick is lost for that second.
- No wrap-around: remaining never decrements below 0. COOK is never entered with remaining==0.
- Illegal state encodings recover to IDLE on the next clk.
- nrst asserted mid-cook: everything clears immediately (async). heat drops in the same cycle.

Decomposition:
- Package microwave_pkg holds:
  - the state enum type (3-bit, values IDLE, OPEN, COOK, PAUSE, BELL);
  - a function computing the power port width from PWR_STEPS.
- One sub-module, tick_prescaler:
  - parameter TICKS;
  - inputs clk, nrst, en, clr;
  - output tick;
  - instantiated once for the seconds tick.
- FSM, timer, bell counter and duty frame stay in the top module.

Test Plan:
Bench parameters: TICKS_PER_SEC=4, PWR_STEPS=4, BELL_SECS=2, CNT_W=4.
1. load_secs=3, load, then start with power=4 -> COOK. heat=1 constantly. remaining reads 2, 1, 0 at clk 4, 8, 12 after entry. BELL for 8 clks, then IDLE with bell=0.
2. power=1 in COOK -> heat pattern 1,0,0,0 repeating; light=1 throughout.
3. Door opens 2 clks into a second -> PAUSE, heat=0, light=1, remaining frozen. Door closes -> COOK. The next decrement comes 2 clks after resume.
4. remaining=0, start -> stays IDLE. start with door=1 -> OPEN. load in OPEN sets remaining, then close -> IDLE.
5. cancel in COOK -> IDLE, remaining=0. cancel in PAUSE -> OPEN, remaining=0. Door in BELL -> OPEN, bell=0.
6. nrst pulsed low mid-COOK -> heat, light, bell, busy and remaining all 0 in the same cycle. State IDLE after release.
